road_scroll_renderer: RTL and testbench



---
 rtl/road_scroll_renderer_if.sv | 23 ++
 rtl/road_scroll_renderer.sv | 59 +++++
 tb/tb_road_scroll_renderer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/road_scroll_renderer_if.sv
// road_scroll_renderer_if: sync-generator inputs and pixel/scroll outputs of the road renderer
interface road_scroll_renderer_if;
  logic        hsync_in;
  logic        vsync_in;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [5:0]  speed;
  logic        pause;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic        frame_tick;
  logic [9:0]  scroll;
  modport master (
    output hsync_in, vsync_in, video_on, pixel_x, pixel_y, speed, pause,
    input  hsync, vsync, rgb, frame_tick, scroll
  );
  modport slave (
    input  hsync_in, vsync_in, video_on, pixel_x, pixel_y, speed, pause,
    output hsync, vsync, rgb, frame_tick, scroll
  );
endinterface

// File: rtl/road_scroll_renderer.sv
// road_scroll_renderer: two-stage pixel pipeline drawing a scrolling three-lane road with a per-frame scroll counter
module road_scroll_renderer #(
  parameter logic [9:0] VD          = 10'd480,
  parameter logic [9:0] ROAD_L      = 10'd160,
  parameter logic [9:0] ROAD_R      = 10'd480,
  parameter logic [9:0] EDGE_W      = 10'd8,
  parameter logic [9:0] LANE1_X     = 10'd264,
  parameter logic [9:0] LANE2_X     = 10'd368,
  parameter logic [9:0] LINE_W      = 10'd8,
  parameter logic [9:0] DASH_PERIOD = 10'd64,
  parameter logic [9:0] DASH_ON     = 10'd32
) (
  input logic clk,
  input logic clr_n,
  road_scroll_renderer_if.slave bus
);
  logic        vo_r, hs_r, vs_r, grass_r, edge_r, line_r, dash_r, tick;
  logic [9:0]  x, scroll_q;
  logic [10:0] ey, s;
  assign x = bus.pixel_x;
  assign bus.scroll = scroll_q;
  always_comb begin
    ey   = (11'(bus.pixel_y) + 11'(DASH_PERIOD) - 11'(scroll_q)) & 11'(DASH_PERIOD - 10'd1);
    s    = 11'(scroll_q) + 11'(bus.speed);
    tick = x == '0 && bus.pixel_y == VD;
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vo_r           <= 1'b0;
      hs_r           <= 1'b0;
      vs_r           <= 1'b0;
      grass_r        <= 1'b0;
      edge_r         <= 1'b0;
      line_r         <= 1'b0;
      dash_r         <= 1'b0;
      bus.hsync      <= 1'b0;
      bus.vsync      <= 1'b0;
      bus.rgb        <= 12'h000;
      bus.frame_tick <= 1'b0;
      scroll_q       <= '0;
    end else begin
      vo_r           <= bus.video_on;
      hs_r           <= bus.hsync_in;
      vs_r           <= bus.vsync_in;
      grass_r        <= x < ROAD_L || x >= ROAD_R;
      edge_r         <= (x >= ROAD_L && x < ROAD_L + EDGE_W) || (x >= ROAD_R - EDGE_W && x < ROAD_R);
      line_r         <= (x >= LANE1_X && x < LANE1_X + LINE_W) || (x >= LANE2_X && x < LANE2_X + LINE_W);
      dash_r         <= ey < 11'(DASH_ON);
      bus.hsync      <= hs_r;
      bus.vsync      <= vs_r;
      bus.rgb        <= !vo_r ? 12'h000 : grass_r ? 12'h0A0 : edge_r ? 12'hFFF :
                        (line_r && dash_r) ? 12'hFF0 : 12'h555;
      bus.frame_tick <= tick;
      // scroll only moves on the blanking-line tick, so a frame always sees one offset
      if (tick && !bus.pause)
        scroll_q <= (s >= 11'(DASH_PERIOD)) ? 10'(s - 11'(DASH_PERIOD)) : 10'(s);
    end
  end
endmodule

// File: tb/tb_road_scroll_renderer.sv
// tb_road_scroll_renderer: directed vector table plus hand sequences for latency, scroll, pause, sweep and async reset
module tb_road_scroll_renderer;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  road_scroll_renderer_if bus();
  road_scroll_renderer dut (.clk(clk), .clr_n(clr_n), .bus(bus));

  typedef struct {
    logic        vo;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic vo, input logic [9:0] x, input logic [9:0] y, input logic hs, input logic vs);
    bus.video_on = vo;
    bus.pixel_x  = x;
    bus.pixel_y  = y;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
  endtask

  task automatic apply(input logic vo, input logic [9:0] x, input logic [9:0] y, input logic hs, input logic vs);
    drive(vo, x, y, hs, vs);
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic tick_frame(input string nm, input logic [5:0] sp, input logic p, input logic [9:0] exp_scroll);
    bus.speed = sp;
    bus.pause = p;
    drive(1'b0, 10'd0, 10'd480, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk({nm, " tick"}, 32'(bus.frame_tick), 32'd1);
    chk({nm, " scroll"}, 32'(bus.scroll), 32'(exp_scroll));
    drive(1'b0, 10'd1, 10'd480, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk({nm, " tick low"}, 32'(bus.frame_tick), 32'd0);
    chk({nm, " scroll hold"}, 32'(bus.scroll), 32'(exp_scroll));
  endtask

  initial begin
    int xs[14] = '{0, 1, 100, 159, 160, 300, 479, 480, 600, 639, 640, 641, 700, 799};
    int ticks, blank_bad, vis_bad;
    logic prev_vis, have_prev, vis;
    tbl.push_back('{1'b1, 10'd100, 10'd10,  1'b1, 1'b0, 12'h0A0});
    tbl.push_back('{1'b1, 10'd164, 10'd10,  1'b0, 1'b1, 12'hFFF});
    tbl.push_back('{1'b1, 10'd476, 10'd10,  1'b1, 1'b1, 12'hFFF});
    tbl.push_back('{1'b1, 10'd200, 10'd10,  1'b0, 1'b0, 12'h555});
    tbl.push_back('{1'b1, 10'd266, 10'd10,  1'b1, 1'b0, 12'hFF0});
    tbl.push_back('{1'b1, 10'd266, 10'd40,  1'b0, 1'b1, 12'h555});
    tbl.push_back('{1'b0, 10'd300, 10'd100, 1'b0, 1'b0, 12'h000});
    tbl.push_back('{1'b1, 10'd159, 10'd20,  1'b0, 1'b0, 12'h0A0});
    tbl.push_back('{1'b1, 10'd160, 10'd20,  1'b0, 1'b0, 12'hFFF});
    tbl.push_back('{1'b1, 10'd167, 10'd20,  1'b0, 1'b0, 12'hFFF});
    tbl.push_back('{1'b1, 10'd168, 10'd20,  1'b0, 1'b0, 12'h555});
    tbl.push_back('{1'b1, 10'd471, 10'd20,  1'b0, 1'b0, 12'h555});
    tbl.push_back('{1'b1, 10'd472, 10'd20,  1'b0, 1'b0, 12'hFFF});
    tbl.push_back('{1'b1, 10'd479, 10'd20,  1'b0, 1'b0, 12'hFFF});
    tbl.push_back('{1'b1, 10'd480, 10'd20,  1'b0, 1'b0, 12'h0A0});
    tbl.push_back('{1'b1, 10'd264, 10'd0,   1'b0, 1'b0, 12'hFF0});
    tbl.push_back('{1'b1, 10'd263, 10'd5,   1'b0, 1'b0, 12'h555});
    tbl.push_back('{1'b1, 10'd271, 10'd31,  1'b0, 1'b0, 12'hFF0});
    tbl.push_back('{1'b1, 10'd272, 10'd31,  1'b0, 1'b0, 12'h555});
    tbl.push_back('{1'b1, 10'd368, 10'd31,  1'b0, 1'b0, 12'hFF0});
    tbl.push_back('{1'b1, 10'd375, 10'd63,  1'b0, 1'b0, 12'h555});
    tbl.push_back('{1'b1, 10'd370, 10'd64,  1'b0, 1'b0, 12'hFF0});
    tbl.push_back('{1'b1, 10'd370, 10'd95,  1'b0, 1'b0, 12'hFF0});
    tbl.push_back('{1'b1, 10'd370, 10'd96,  1'b0, 1'b0, 12'h555});
    tbl.push_back('{1'b0, 10'd266, 10'd10,  1'b1, 1'b1, 12'h000});

    bus.speed = 6'd0;
    bus.pause = 1'b0;
    drive(1'b1, 10'd100, 10'd10, 1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset rgb", 32'(bus.rgb), 32'h000);
    chk("reset hsync", 32'(bus.hsync), 32'd0);
    chk("reset vsync", 32'(bus.vsync), 32'd0);
    chk("reset tick", 32'(bus.frame_tick), 32'd0);
    chk("reset scroll", 32'(bus.scroll), 32'd0);
    clr_n = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].vo, tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs);
      chk($sformatf("vec%0d rgb", i), 32'(bus.rgb), 32'(tbl[i].rgb));
      chk($sformatf("vec%0d hsync", i), 32'(bus.hsync), 32'(tbl[i].hs));
      chk($sformatf("vec%0d vsync", i), 32'(bus.vsync), 32'(tbl[i].vs));
    end

    apply(1'b0, 10'd300, 10'd100, 1'b0, 1'b0);
    drive(1'b1, 10'd100, 10'd10, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 10'd200, 10'd10, 1'b0, 1'b1);
    chk("lat t+1 rgb", 32'(bus.rgb), 32'h000);
    chk("lat t+1 hsync", 32'(bus.hsync), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 10'd200, 10'd10, 1'b0, 1'b0);
    chk("lat t+2 rgb", 32'(bus.rgb), 32'h0A0);
    chk("lat t+2 hsync", 32'(bus.hsync), 32'd1);
    chk("lat t+2 vsync", 32'(bus.vsync), 32'd0);
    @(posedge clk);
    #1;
    chk("lat t+3 rgb", 32'(bus.rgb), 32'h555);
    chk("lat t+3 hsync", 32'(bus.hsync), 32'd0);
    chk("lat t+3 vsync", 32'(bus.vsync), 32'd1);

    tick_frame("to16", 6'd16, 1'b0, 10'd16);
    apply(1'b1, 10'd266, 10'd40, 1'b0, 1'b0);
    chk("scroll16 y40 rgb", 32'(bus.rgb), 32'hFF0);
    apply(1'b1, 10'd266, 10'd10, 1'b0, 1'b0);
    chk("scroll16 y10 rgb", 32'(bus.rgb), 32'h555);
    tick_frame("to60", 6'd44, 1'b0, 10'd60);
    tick_frame("wrap", 6'd5, 1'b0, 10'd1);
    tick_frame("speed0", 6'd0, 1'b0, 10'd1);
    tick_frame("pause", 6'd5, 1'b1, 10'd1);
    tick_frame("unpause", 6'd5, 1'b0, 10'd6);

    bus.speed = 6'd3;
    bus.pause = 1'b0;
    ticks = 0;
    blank_bad = 0;
    vis_bad = 0;
    have_prev = 1'b0;
    prev_vis = 1'b0;
    for (int y = 0; y < 525; y++) begin
      for (int k = 0; k < 14; k++) begin
        vis = xs[k] < 640 && y < 480;
        drive(vis, 10'(xs[k]), 10'(y), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        if (have_prev && !prev_vis && bus.rgb != 12'h000) blank_bad++;
        if (have_prev && prev_vis && bus.rgb == 12'h000) vis_bad++;
        if (bus.frame_tick) ticks++;
        prev_vis = vis;
        have_prev = 1'b1;
      end
    end
    chk("sweep ticks", 32'(ticks), 32'd1);
    chk("sweep blank nonzero", 32'(blank_bad), 32'd0);
    chk("sweep visible black", 32'(vis_bad), 32'd0);
    chk("sweep scroll", 32'(bus.scroll), 32'd9);

    apply(1'b1, 10'd100, 10'd10, 1'b1, 1'b1);
    chk("pre-reset rgb", 32'(bus.rgb), 32'h0A0);
    chk("pre-reset hsync", 32'(bus.hsync), 32'd1);
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    chk("async rgb", 32'(bus.rgb), 32'h000);
    chk("async hsync", 32'(bus.hsync), 32'd0);
    chk("async vsync", 32'(bus.vsync), 32'd0);
    chk("async scroll", 32'(bus.scroll), 32'd0);
    #2;
    clr_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset t+1 rgb", 32'(bus.rgb), 32'h000);
    @(posedge clk);
    #1;
    chk("post-reset t+2 rgb", 32'(bus.rgb), 32'h0A0);
    chk("post-reset t+2 hsync", 32'(bus.hsync), 32'd1);
    chk("post-reset scroll", 32'(bus.scroll), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
